amdc_inv_status_filter: RTL and testbench

// - Upstream conditioning stage for amdc_inv_status_mux: takes raw inverter status pins
//   (ready, fault, etc.) for every inverter channel, synchronises them to ACLK,

---
 rtl/amdc_inv_status_filter.sv | 126 ++++++++++++
 tb/tb_amdc_inv_status_filter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/amdc_inv_status_filter.sv
// Inverter status conditioning: 2-flop sync, per-bit debounce, sticky fault latch and irq.
// Optional glitch counter enabled by defining INV_STATUS_GLITCH_CNT_EN.
module amdc_inv_status_filter #(
    parameter int N_CH            = 8,
    parameter int BITS_PER_CH     = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter logic [BITS_PER_CH-1:0] FAULT_MASK = 4'b0010
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic [N_CH*BITS_PER_CH-1:0] status_raw,
    input  logic [N_CH-1:0]           fault_clr,
    input  logic                      glitch_clr,
    output logic [N_CH*BITS_PER_CH-1:0] status_filt,
    output logic [N_CH*BITS_PER_CH-1:0] fault_latched,
    output logic                      fault_irq,
    output logic [15:0]               glitch_count
);

    localparam int W     = N_CH * BITS_PER_CH;
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [W-1:0]     sync1_r;
    logic [W-1:0]     sync2_r;
    logic [W-1:0]     filt_r;
    logic [W-1:0]     latched_r;
    logic             irq_r;
    logic [CNT_W-1:0] cnt_r      [W];
    logic [CNT_W-1:0] cnt_next_s [W];
    logic [W-1:0]     filt_next_s;
    logic [W-1:0]     fault_mask_s;
    logic [W-1:0]     clr_mask_s;
    logic [W-1:0]     latched_next_s;
    logic             irq_next_s;
    logic             glitch_s;

    // Debounce: a bit must disagree with filt for DEBOUNCE_CYCLES consecutive cycles to flip.
    always_comb begin
        filt_next_s = filt_r;
        glitch_s    = 1'b0;
        for (int i = 0; i < W; i++) begin
            cnt_next_s[i] = cnt_r[i];
            if (sync2_r[i] != filt_r[i]) begin
                if (cnt_r[i] == CNT_MAX) begin
                    filt_next_s[i] = sync2_r[i];
                    cnt_next_s[i]  = {CNT_W{1'b0}};
                end else begin
                    cnt_next_s[i] = cnt_r[i] + CNT_W'(1);
                end
            end else begin
                cnt_next_s[i] = {CNT_W{1'b0}};
                if (cnt_r[i] != {CNT_W{1'b0}}) begin
                    glitch_s = 1'b1;
                end else begin
                    glitch_s = glitch_s;
                end
            end
        end
    end

    // Fault latch: active filtered faults set (and win over clear), clears only hit inactive bits.
    always_comb begin
        fault_mask_s = {W{1'b0}};
        clr_mask_s   = {W{1'b0}};
        for (int c = 0; c < N_CH; c++) begin
            for (int b = 0; b < BITS_PER_CH; b++) begin
                fault_mask_s[c*BITS_PER_CH+b] = FAULT_MASK[b];
                clr_mask_s[c*BITS_PER_CH+b]   = fault_clr[c];
            end
        end
        latched_next_s = ((latched_r & ~(clr_mask_s & ~filt_r)) | filt_r) & fault_mask_s;
        irq_next_s     = |(latched_next_s & ~latched_r);
    end

    // Synchroniser, debounce state, fault latch and irq registers.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            sync1_r   <= {W{1'b0}};
            sync2_r   <= {W{1'b0}};
            filt_r    <= {W{1'b0}};
            latched_r <= {W{1'b0}};
            irq_r     <= 1'b0;
            for (int i = 0; i < W; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            sync1_r   <= status_raw;
            sync2_r   <= sync1_r;
            filt_r    <= filt_next_s;
            latched_r <= latched_next_s;
            irq_r     <= irq_next_s;
            for (int i = 0; i < W; i++) begin
                cnt_r[i] <= cnt_next_s[i];
            end
        end
    end

    assign status_filt   = filt_r;
    assign fault_latched = latched_r;
    assign fault_irq     = irq_r;

`ifdef INV_STATUS_GLITCH_CNT_EN
    logic [15:0] glitch_cnt_r;

    // Saturating glitch counter; clear takes priority over a coincident glitch.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            glitch_cnt_r <= 16'h0000;
        end else if (glitch_clr) begin
            glitch_cnt_r <= 16'h0000;
        end else if (glitch_s && (glitch_cnt_r != 16'hFFFF)) begin
            glitch_cnt_r <= glitch_cnt_r + 16'd1;
        end else begin
            glitch_cnt_r <= glitch_cnt_r;
        end
    end

    assign glitch_count = glitch_cnt_r;
`else
    logic unused_glitch_s;
    assign unused_glitch_s = glitch_clr ^ glitch_s;
    assign glitch_count    = 16'h0000;
`endif

endmodule

// File: tb/tb_amdc_inv_status_filter.sv
// Self-checking bench for amdc_inv_status_filter (DEBOUNCE_CYCLES=4) with a behavioural model.
module tb_amdc_inv_status_filter;

    localparam int N_CH = 8;
    localparam int BPC  = 4;
    localparam int D    = 4;
    localparam int W    = N_CH * BPC;
    localparam logic [BPC-1:0] FM = 4'b0010;

    logic          ACLK = 1'b0;
    logic          ARESETN;
    logic [W-1:0]  status_raw;
    logic [N_CH-1:0] fault_clr;
    logic          glitch_clr;
    logic [W-1:0]  status_filt;
    logic [W-1:0]  fault_latched;
    logic          fault_irq;
    logic [15:0]   glitch_count;

    amdc_inv_status_filter #(
        .N_CH(N_CH), .BITS_PER_CH(BPC), .DEBOUNCE_CYCLES(D), .FAULT_MASK(FM)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .status_raw(status_raw), .fault_clr(fault_clr),
        .glitch_clr(glitch_clr), .status_filt(status_filt), .fault_latched(fault_latched),
        .fault_irq(fault_irq), .glitch_count(glitch_count)
    );

    always #5 ACLK = ~ACLK;

    // Model state: raw samples from the last two edges, accepted value, disagreement run length.
    logic [W-1:0] m_samp0, m_samp1, m_filt, m_lat;
    logic         m_irq;
    int           m_run [W];
    int           m_gcnt;
    int           n_checks = 0;
    int           n_pass   = 0;
    int           irq_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_edge();
        logic [W-1:0] nf;
        logic [W-1:0] nl;
        bit           gl;
        if (!ARESETN) begin
            m_samp0 = '0; m_samp1 = '0; m_filt = '0; m_lat = '0; m_irq = 1'b0; m_gcnt = 0;
            for (int i = 0; i < W; i++) m_run[i] = 0;
        end else begin
            nf = m_filt;
            gl = 1'b0;
            // A new value is accepted after D consecutive synchronised samples disagree.
            for (int i = 0; i < W; i++) begin
                if (m_samp1[i] != m_filt[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D) begin
                        nf[i] = m_samp1[i];
                        m_run[i] = 0;
                    end
                end else begin
                    if (m_run[i] > 0) gl = 1'b1;
                    m_run[i] = 0;
                end
            end
            for (int c = 0; c < N_CH; c++) begin
                for (int b = 0; b < BPC; b++) begin
                    int i;
                    i = c * BPC + b;
                    if (!FM[b]) nl[i] = 1'b0;
                    else if (m_filt[i]) nl[i] = 1'b1;
                    else if (fault_clr[c]) nl[i] = 1'b0;
                    else nl[i] = m_lat[i];
                end
            end
            m_irq = |(nl & ~m_lat);
`ifdef INV_STATUS_GLITCH_CNT_EN
            if (glitch_clr) m_gcnt = 0;
            else if (gl && m_gcnt < 65535) m_gcnt++;
`else
            m_gcnt = 0;
`endif
            m_samp1 = m_samp0;
            m_samp0 = status_raw;
            m_filt  = nf;
            m_lat   = nl;
        end
    endtask

    // One clock: advance the model at the edge, compare every output on the falling edge.
    task automatic step();
        @(posedge ACLK);
        model_edge();
        @(negedge ACLK);
        check("status_filt", status_filt, m_filt);
        check("fault_latched", fault_latched, m_lat);
        check("fault_irq", {31'd0, fault_irq}, {31'd0, m_irq});
        check("glitch_count", {16'd0, glitch_count}, m_gcnt);
        if (fault_irq) irq_seen++;
    endtask

    initial begin
        ARESETN    = 1'b0;
        status_raw = 32'hFFFF_FFFF;
        fault_clr  = 8'h00;
        glitch_clr = 1'b0;
        @(negedge ACLK);
        repeat (3) step();

        // Reset release: outputs stay 0 for 5 edges, filt follows at the 6th.
        ARESETN = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("reset_hold_filt", status_filt, 32'h0000_0000);
        end
        step();
        check("reset_filt_all1", status_filt, 32'hFFFF_FFFF);
        step();
        check("reset_latched", fault_latched, 32'h2222_2222);
        check("reset_irq", {31'd0, fault_irq}, 32'd1);
        step();
        check("reset_irq_once", {31'd0, fault_irq}, 32'd0);
        status_raw = 32'h0000_0000;
        repeat (8) step();
        fault_clr = 8'hFF;
        step();
        fault_clr = 8'h00;
        check("reset_fault_cleared", fault_latched, 32'h0000_0000);

        // Latency: filt[0] rises exactly on the 6th edge after first sampling.
        status_raw = 32'h0000_0001;
        repeat (5) step();
        check("latency_before", {31'd0, status_filt[0]}, 32'd0);
        step();
        check("latency_at", {31'd0, status_filt[0]}, 32'd1);
        status_raw = 32'h0000_0000;
        repeat (8) step();

        // Glitch rejection: 3-cycle pulse never reaches filt.
        status_raw = 32'h0000_0001;
        repeat (3) step();
        status_raw = 32'h0000_0000;
        repeat (8) step();
        check("glitch_filt", status_filt, 32'h0000_0000);
`ifdef INV_STATUS_GLITCH_CNT_EN
        check("glitch_count_1", {16'd0, glitch_count}, 32'd1);
`else
        check("glitch_count_0", {16'd0, glitch_count}, 32'd0);
`endif

        // Fault latch and clear on channel 1.
        irq_seen   = 0;
        status_raw = 32'h0000_0020;
        repeat (8) step();
        fault_clr = 8'h02;
        step();
        fault_clr = 8'h00;
        check("fault_clr_active", fault_latched, 32'h0000_0020);
        step();
        status_raw = 32'h0000_0000;
        repeat (8) step();
        check("fault_filt_gone", status_filt, 32'h0000_0000);
        check("fault_still_latched", fault_latched, 32'h0000_0020);
        fault_clr = 8'h02;
        step();
        fault_clr = 8'h00;
        check("fault_cleared", fault_latched, 32'h0000_0000);
        check("fault_clr_no_irq", {31'd0, fault_irq}, 32'd0);
        check("fault_irq_count", irq_seen, 32'd1);

        // Simultaneous faults on ch0 and ch7.
        irq_seen   = 0;
        status_raw = 32'h2000_0002;
        repeat (7) step();
        check("simul_latched", fault_latched, 32'h2000_0002);
        repeat (3) step();
        check("simul_irq_count", irq_seen, 32'd1);
        status_raw = 32'h0000_0000;
        repeat (8) step();
        fault_clr = 8'hFF;
        step();
        fault_clr = 8'h00;

        // Reset mid-debounce discards progress.
        status_raw = 32'hFFFF_FFFF;
        repeat (4) step();
        ARESETN = 1'b0;
        step();
        ARESETN    = 1'b1;
        status_raw = 32'h0000_0000;
        repeat (8) step();
        check("mid_reset_filt", status_filt, 32'h0000_0000);
        glitch_clr = 1'b1;
        step();
        glitch_clr = 1'b0;

`ifdef INV_STATUS_GLITCH_CNT_EN
        // Saturation: interleaved 1-cycle pulses give a glitch on every cycle.
        for (int k = 0; k < 65545; k++) begin
            status_raw = k[0] ? 32'h5555_5555 : 32'hAAAA_AAAA;
            step();
        end
        check("glitch_saturated", {16'd0, glitch_count}, 32'h0000_FFFF);
        status_raw = 32'h5555_5555;
        glitch_clr = 1'b1;
        step();
        glitch_clr = 1'b0;
        check("glitch_clr_wins", {16'd0, glitch_count}, 32'd0);
        status_raw = 32'hAAAA_AAAA;
        step();
        check("glitch_after_clr", {16'd0, glitch_count}, 32'd1);
        status_raw = 32'h0000_0000;
        repeat (6) step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
